// File: rtl/dt_tree_traverser_pkg.sv
// Node word layout, FSM state encoding and result codes shared by the tree traverser.
// Field positions are given for the default NODE_AW=8 / CLASS_W=4 layout.
package dt_pkg;

    localparam int DEF_NODE_AW = 8;
    localparam int DEF_CLASS_W = 4;
    localparam int FID_W       = 3;
    localparam int THR_W       = 32;

    localparam int CLASS_LSB = 0;
    localparam int CLASS_MSB = CLASS_LSB + DEF_CLASS_W - 1;
    localparam int RIGHT_LSB = CLASS_MSB + 1;
    localparam int RIGHT_MSB = RIGHT_LSB + DEF_NODE_AW - 1;
    localparam int LEFT_LSB  = RIGHT_MSB + 1;
    localparam int LEFT_MSB  = LEFT_LSB + DEF_NODE_AW - 1;
    localparam int THR_LSB   = LEFT_MSB + 1;
    localparam int THR_MSB   = THR_LSB + THR_W - 1;
    localparam int FID_LSB   = THR_MSB + 1;
    localparam int FID_MSB   = FID_LSB + FID_W - 1;
    localparam int LEAF_BIT  = FID_MSB + 1;

    function automatic int NODE_W(input int aw, input int cw);
        return 36 + 2 * aw + cw;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WAIT_SEL,
        DONE
    } state_t;

    localparam logic [1:0] RC_OK      = 2'd0;
    localparam logic [1:0] RC_BADFID  = 2'd1;
    localparam logic [1:0] RC_DEPTH   = 2'd2;
    localparam logic [1:0] RC_TIMEOUT = 2'd3;

endpackage

// File: rtl/dt_tree_traverser_if.sv
// Bundles the start/result, node-table and feature-selector signals of the traverser.
// master is the traverser side; slave is the surrounding node ROM / selector / consumer.
interface dt_tree_traverser_if
    import dt_pkg::*;
#(
    parameter int NODE_AW = 8,
    parameter int CLASS_W = 4
);
    logic                                start;
    logic                                busy;
    logic                                node_rd_en;
    logic [NODE_AW-1:0]                  node_addr;
    logic [NODE_W(NODE_AW, CLASS_W)-1:0] node_rdata;
    logic                                sel_valid;
    logic [FID_W-1:0]                    sel_feature_id;
    logic [THR_W-1:0]                    sel_data;
    logic                                sel_valid_out;
    logic                                sel_error;
    logic                                result_valid;
    logic [CLASS_W-1:0]                  result_class;
    logic                                result_error;
    logic [1:0]                          result_code;
    logic [4:0]                          result_depth;

    modport master (
        input  start, node_rdata, sel_data, sel_valid_out, sel_error,
        output busy, node_rd_en, node_addr, sel_valid, sel_feature_id,
               result_valid, result_class, result_error, result_code, result_depth
    );

    modport slave (
        output start, node_rdata, sel_data, sel_valid_out, sel_error,
        input  busy, node_rd_en, node_addr, sel_valid, sel_feature_id,
               result_valid, result_class, result_error, result_code, result_depth
    );
endinterface

// File: rtl/dt_node_unpack.sv
// Splits a node table word into its named fields; purely combinational, no state.
// Offsets shift with NODE_AW / CLASS_W relative to the default layout.
module dt_node_unpack
    import dt_pkg::*;
#(
    parameter int NODE_AW = 8,
    parameter int CLASS_W = 4
) (
    input  logic [NODE_W(NODE_AW, CLASS_W)-1:0] node,
    output logic                                is_leaf,
    output logic [FID_W-1:0]                    fid,
    output logic [THR_W-1:0]                    thr,
    output logic [NODE_AW-1:0]                  left,
    output logic [NODE_AW-1:0]                  right,
    output logic [CLASS_W-1:0]                  cls
);
    localparam int CD = CLASS_W - DEF_CLASS_W;
    localparam int AD = NODE_AW - DEF_NODE_AW;

    assign cls     = node[CLASS_MSB + CD : CLASS_LSB];
    assign right   = node[RIGHT_MSB + CD + AD : RIGHT_LSB + CD];
    assign left    = node[LEFT_MSB + CD + 2*AD : LEFT_LSB + CD + AD];
    assign thr     = node[THR_MSB + CD + 2*AD : THR_LSB + CD + 2*AD];
    assign fid     = node[FID_MSB + CD + 2*AD : FID_LSB + CD + 2*AD];
    assign is_leaf = node[LEAF_BIT + CD + 2*AD];
endmodule

// File: rtl/dt_tree_traverser.sv
// Walks the node table root-to-leaf, one feature compare per internal node.
// Latency 3 cycles per internal node + 3; no backpressure, start is ignored while busy.
module dt_tree_traverser
    import dt_pkg::*;
#(
    parameter int NODE_AW     = 8,
    parameter int CLASS_W     = 4,
    parameter int MAX_DEPTH   = 16,
    parameter int SEL_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dt_tree_traverser_if.master bus
);
    localparam int TMO_W = $clog2(SEL_TIMEOUT + 1);

    state_t             state;
    logic [4:0]         depth;
    logic [TMO_W-1:0]   tmo;
    logic [THR_W-1:0]   thr_q;
    logic [NODE_AW-1:0] left_q;
    logic [NODE_AW-1:0] right_q;

    logic               f_leaf;
    logic [FID_W-1:0]   f_fid;
    logic [THR_W-1:0]   f_thr;
    logic [NODE_AW-1:0] f_left;
    logic [NODE_AW-1:0] f_right;
    logic [CLASS_W-1:0] f_class;

    logic               fin;
    logic [1:0]         fin_code;

    dt_node_unpack #(
        .NODE_AW (NODE_AW),
        .CLASS_W (CLASS_W)
    ) u_unpack (
        .node    (bus.node_rdata),
        .is_leaf (f_leaf),
        .fid     (f_fid),
        .thr     (f_thr),
        .left    (f_left),
        .right   (f_right),
        .cls     (f_class)
    );

    // Every way of ending an inference funnels through fin so DONE bookkeeping lives in one place.
    always_comb begin
        fin      = 1'b0;
        fin_code = RC_OK;
        case (state)
            DECODE: begin
                if (f_leaf) begin
                    fin = 1'b1;
                end else if (depth == 5'(MAX_DEPTH)) begin
                    fin      = 1'b1;
                    fin_code = RC_DEPTH;
                end
            end
            WAIT_SEL: begin
                if (bus.sel_valid_out) begin
                    if (bus.sel_error) begin
                        fin      = 1'b1;
                        fin_code = RC_BADFID;
                    end
                end else if (tmo == TMO_W'(SEL_TIMEOUT - 1)) begin
                    fin      = 1'b1;
                    fin_code = RC_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            depth              <= '0;
            tmo                <= '0;
            thr_q              <= '0;
            left_q             <= '0;
            right_q            <= '0;
            bus.busy           <= 1'b0;
            bus.node_rd_en     <= 1'b0;
            bus.node_addr      <= '0;
            bus.sel_valid      <= 1'b0;
            bus.sel_feature_id <= '0;
            bus.result_valid   <= 1'b0;
            bus.result_class   <= '0;
            bus.result_error   <= 1'b0;
            bus.result_code    <= RC_OK;
            bus.result_depth   <= '0;
        end else begin
            bus.node_rd_en   <= 1'b0;
            bus.sel_valid    <= 1'b0;
            bus.result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= FETCH;
                        depth          <= '0;
                        bus.node_addr  <= '0;
                        bus.node_rd_en <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    thr_q   <= f_thr;
                    left_q  <= f_left;
                    right_q <= f_right;
                    if (!fin) begin
                        bus.sel_valid      <= 1'b1;
                        bus.sel_feature_id <= f_fid;
                        tmo                <= '0;
                        state              <= WAIT_SEL;
                    end
                end
                WAIT_SEL: begin
                    if (bus.sel_valid_out) begin
                        if (!bus.sel_error) begin
                            bus.node_addr  <= ($signed(bus.sel_data) <= $signed(thr_q)) ? left_q : right_q;
                            bus.node_rd_en <= 1'b1;
                            depth          <= depth + 5'd1;
                            state          <= FETCH;
                        end
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (fin) begin
                state            <= DONE;
                bus.result_valid <= 1'b1;
                bus.result_error <= (fin_code != RC_OK);
                bus.result_code  <= fin_code;
                bus.result_class <= (fin_code == RC_OK) ? f_class : '0;
                bus.result_depth <= depth;
            end
        end
    end
endmodule

// File: tb/tb_dt_tree_traverser.sv
// Randomized and directed checks of dt_tree_traverser against a tree-walking reference model.
module tb_dt_tree_traverser;

    typedef struct {
        int cyc;
        int cls;
        int code;
        int dep;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    dt_tree_traverser_if bus ();

    dt_tree_traverser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tree kept as plain field arrays; the ROM image is rebuilt from them.
    int          nd_leaf [256];
    int          nd_fid  [256];
    logic [31:0] nd_thr  [256];
    int          nd_left [256];
    int          nd_right[256];
    int          nd_cls  [256];
    logic [55:0] rom     [256];
    logic [31:0] feat    [6];

    logic stall;
    logic stray;
    bit   checking = 0;

    exp_t exp_q[$];
    int   vtimes[$];
    int   bfrom = 0;
    int   bto   = -1;

    int n_cmp  = 0;
    int n_fail = 0;

    always @(posedge clk)
        if (bus.node_rd_en) bus.node_rdata <= rom[bus.node_addr];

    always_comb begin
        bus.sel_valid_out = (bus.sel_valid & ~stall) | stray;
        bus.sel_error     = (bus.sel_feature_id >= 3'd6);
        bus.sel_data      = (bus.sel_feature_id < 3'd6) ? feat[bus.sel_feature_id] : 32'd0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model(input bit stl, output int lat, output int cls,
                                  output int code, output int dep);
        int a = 0;
        int d = 0;
        lat = 0; cls = 0; code = 0; dep = 0;
        for (int g = 0; g < 64; g++) begin
            dep = d;
            if (nd_leaf[a] != 0) begin cls = nd_cls[a]; lat = 3*d + 3; return; end
            if (d == 16)          begin code = 2;       lat = 3*d + 3; return; end
            if (stl)              begin code = 3;       lat = 3*d + 7; return; end
            if (nd_fid[a] >= 6)   begin code = 1;       lat = 3*d + 4; return; end
            a = ($signed(feat[nd_fid[a]]) <= $signed(nd_thr[a])) ? nd_left[a] : nd_right[a];
            d++;
        end
    endfunction

    task automatic set_node(input int a, input int leaf, input int fid, input logic [31:0] thr,
                            input int l, input int r, input int cls);
        nd_leaf[a] = leaf; nd_fid[a] = fid; nd_thr[a] = thr;
        nd_left[a] = l; nd_right[a] = r; nd_cls[a] = cls;
    endtask

    task automatic clear_tree();
        for (int i = 0; i < 256; i++) set_node(i, 1, 0, 32'd0, 0, 0, 0);
    endtask

    task automatic sync_rom();
        for (int i = 0; i < 256; i++)
            rom[i] = {nd_leaf[i][0], nd_fid[i][2:0], nd_thr[i], nd_left[i][7:0],
                      nd_right[i][7:0], nd_cls[i][3:0]};
    endtask

    task automatic pin_model(input string name, input int lat_e, input int cls_e,
                             input int code_e, input int dep_e);
        int lat, cls, code, dep;
        model(stall, lat, cls, code, dep);
        chk({name, "_latency"}, lat,  lat_e);
        chk({name, "_class"},   cls,  cls_e);
        chk({name, "_code"},    code, code_e);
        chk({name, "_depth"},   dep,  dep_e);
    endtask

    // Called at a negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic launch(input bit noise);
        int lat, cls, code, dep;
        exp_t e;
        model(stall, lat, cls, code, dep);
        e.cyc = cyc + lat; e.cls = cls; e.code = code; e.dep = dep;
        exp_q.push_back(e);
        bfrom = cyc + 1;
        bto   = cyc + lat;
        bus.start = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            bus.start = noise ? 1'($urandom % 2) : 1'b0;
            stray     = noise && !stall && ($urandom % 4 == 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        stray     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            bit exp_v;
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("result_valid", bus.result_valid, exp_v);
            if (exp_v) begin
                chk("result_class", bus.result_class, exp_q[0].cls);
                chk("result_error", bus.result_error, exp_q[0].code != 0);
                chk("result_code",  bus.result_code,  exp_q[0].code);
                chk("result_depth", bus.result_depth, exp_q[0].dep);
                vtimes.push_back(cyc);
                void'(exp_q.pop_front());
            end
            chk("busy", bus.busy, (cyc >= bfrom) && (cyc <= bto));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        rst_n = 1'b0;
        bus.start = 1'b0;
        stall = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) feat[i] = 32'd0;
        clear_tree();
        sync_rom();
        repeat (3) @(negedge clk);
        chk("rst_busy",         bus.busy,           0);
        chk("rst_node_rd_en",   bus.node_rd_en,     0);
        chk("rst_node_addr",    bus.node_addr,      0);
        chk("rst_sel_valid",    bus.sel_valid,      0);
        chk("rst_sel_fid",      bus.sel_feature_id, 0);
        chk("rst_result_valid", bus.result_valid,   0);
        chk("rst_result_class", bus.result_class,   0);
        chk("rst_result_error", bus.result_error,   0);
        chk("rst_result_code",  bus.result_code,    0);
        chk("rst_result_depth", bus.result_depth,   0);
        rst_n = 1'b1;
        checking = 1;
        @(negedge clk);

        // Root leaf
        set_node(0, 1, 0, 32'd0, 0, 0, 5); sync_rom();
        pin_model("root_leaf", 3, 5, 0, 0);
        launch(0);

        // One compare, both directions and equality
        set_node(0, 0, 2, 32'h0001_0000, 1, 2, 0);
        set_node(1, 1, 0, 32'd0, 0, 0, 1);
        set_node(2, 1, 0, 32'd0, 0, 0, 2);
        sync_rom();
        feat[2] = 32'h0000_8000; pin_model("go_left", 6, 1, 0, 1);  launch(0);
        feat[2] = 32'h0001_8000; pin_model("go_right", 6, 2, 0, 1); launch(0);
        feat[2] = 32'h0001_0000; pin_model("equal", 6, 1, 0, 1);    launch(0);
        set_node(0, 0, 2, 32'd0, 1, 2, 0); sync_rom();
        feat[2] = 32'hFFFF_0000; pin_model("signed", 6, 1, 0, 1);   launch(0);

        // Error codes
        set_node(0, 0, 6, 32'd0, 1, 2, 0); sync_rom();
        pin_model("bad_fid", 4, 0, 1, 0); launch(0);
        set_node(0, 0, 0, 32'd0, 0, 0, 0); sync_rom();
        pin_model("depth_ovf", 51, 0, 2, 16); launch(0);

        // Selector timeout, then reset in the middle of WAIT_SEL
        set_node(0, 0, 0, 32'd0, 1, 2, 0); sync_rom();
        stall = 1'b1;
        pin_model("timeout", 7, 0, 3, 0); launch(0);
        s = cyc;
        bfrom = s + 1;
        bto   = s + 100;
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        bto = cyc;
        #1;
        chk("midrst_busy",         bus.busy,         0);
        chk("midrst_result_valid", bus.result_valid, 0);
        chk("midrst_sel_valid",    bus.sel_valid,    0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back depth-2 inferences with start toggling while busy
        clear_tree();
        set_node(0, 0, 1, 32'd0, 1, 3, 0);
        set_node(1, 0, 3, 32'h0000_0100, 4, 5, 0);
        set_node(4, 1, 0, 32'd0, 0, 0, 7);
        set_node(5, 1, 0, 32'd0, 0, 0, 8);
        sync_rom();
        feat[1] = 32'hFFFF_FFFB; feat[3] = 32'h0000_0100;
        pin_model("depth2", 9, 7, 0, 2);
        vtimes.delete();
        launch(1); launch(1); launch(1);
        repeat (2) @(negedge clk);
        chk("b2b_count", vtimes.size(), 3);
        if (vtimes.size() == 3) begin
            chk("b2b_gap1", vtimes[1] - vtimes[0], 10);
            chk("b2b_gap2", vtimes[2] - vtimes[1], 10);
        end

        // Random trees and features
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) begin
                clear_tree();
                for (int i = 0; i < 16; i++)
                    set_node(i, ($urandom % 3 == 0) ? 1 : 0,
                             ($urandom % 10 == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6),
                             $urandom, $urandom % 16, $urandom % 16, $urandom % 16);
                sync_rom();
            end
            for (int k = 0; k < 6; k++)
                feat[k] = ($urandom % 3 == 0) ? nd_thr[$urandom % 16] : $urandom;
            launch(1);
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
